// File: rtl/svm_dag_pkg.sv
// Shared types, defaults and constant pair tables for the decision-DAG SVM picker.
package svm_dag_pkg;

  localparam int DEF_N_CLASS    = 4;
  localparam int DEF_N_FEATURES = 21;
  localparam int DEF_WEIGHT_W   = 8;
  localparam int DEF_BIAS_W     = 16;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_e;

  // Linear index of pair (i,j), i<j, in row-major upper-triangle order.
  function automatic int pair_index(int i, int j, int n);
    return i * n - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

  // Trained-model tables stand in as closed-form constants; only elaborated at build time.
  function automatic int rom_weight(int p, int f);
    return ((p * 37 + f * 11 + 5) % 256) - 128;
  endfunction

  function automatic int rom_bias(int p);
    return p * 1000 - 2500;
  endfunction

endpackage

// File: rtl/svm_pair_rom.sv
// Combinational weight/bias lookup per classifier pair; feature f sits at weight[f*WEIGHT_W +: WEIGHT_W].
module svm_pair_rom
  import svm_dag_pkg::*;
#(
  parameter int N_PAIRS    = 6,
  parameter int PAIR_W     = 3,
  parameter int N_FEATURES = DEF_N_FEATURES,
  parameter int WEIGHT_W   = DEF_WEIGHT_W,
  parameter int BIAS_W     = DEF_BIAS_W
) (
  input  logic [PAIR_W-1:0]              pair_idx,
  output logic [WEIGHT_W*N_FEATURES-1:0] weight,
  output logic [BIAS_W-1:0]              bias
);

  logic [N_PAIRS-1:0][WEIGHT_W*N_FEATURES-1:0] w_tbl;
  logic [N_PAIRS-1:0][BIAS_W-1:0]              b_tbl;

  for (genvar p = 0; p < N_PAIRS; p++) begin : g_pair
    for (genvar f = 0; f < N_FEATURES; f++) begin : g_feat
      assign w_tbl[p][f*WEIGHT_W +: WEIGHT_W] = WEIGHT_W'(rom_weight(p, f));
    end
    assign b_tbl[p] = BIAS_W'(rom_bias(p));
  end

  // Unused index codes above N_PAIRS-1 read as zero.
  always_comb begin
    weight = '0;
    bias   = '0;
    for (int p = 0; p < N_PAIRS; p++) begin
      if (pair_idx == PAIR_W'(p)) begin
        weight = w_tbl[p];
        bias   = b_tbl[p];
      end
    end
  end

endmodule

// File: rtl/svm_dag_picker.sv
// DDAG one-vs-one controller: shrinks [lo,hi] one class per SVM verdict over a shared SVM core.
module svm_dag_picker
  import svm_dag_pkg::*;
#(
  parameter int N_CLASS    = DEF_N_CLASS,
  parameter int N_FEATURES = DEF_N_FEATURES,
  parameter int WEIGHT_W   = DEF_WEIGHT_W,
  parameter int BIAS_W     = DEF_BIAS_W,
  parameter int CLS_W      = $clog2(N_CLASS),
  parameter int PAIR_W     = ((N_CLASS * (N_CLASS - 1) / 2) > 1) ?
                             $clog2(N_CLASS * (N_CLASS - 1) / 2) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           svm_ready,
  input  logic                           w_class,
  output logic                           svm_req,
  output logic [WEIGHT_W*N_FEATURES-1:0] weight,
  output logic [BIAS_W-1:0]              bias,
  output logic [PAIR_W-1:0]              pair_idx,
  output logic                           busy,
  output logic                           ready,
  output logic [CLS_W-1:0]               winner
);

  localparam int                N_PAIRS  = N_CLASS * (N_CLASS - 1) / 2;
  localparam logic [CLS_W-1:0]  HI_RST   = CLS_W'(N_CLASS - 1);
  localparam logic [PAIR_W-1:0] PAIR_RST = PAIR_W'(pair_index(0, N_CLASS - 1, N_CLASS));

  state_e           state;
  logic [CLS_W-1:0] lo, hi, nlo, nhi;

  always_comb begin
    nlo = lo;
    nhi = hi;
    if (w_class) nlo = lo + CLS_W'(1);
    else         nhi = hi - CLS_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lo       <= '0;
      hi       <= HI_RST;
      pair_idx <= PAIR_RST;
      svm_req  <= 1'b0;
      busy     <= 1'b0;
      ready    <= 1'b0;
      winner   <= '0;
    end else begin
      svm_req <= 1'b0;
      ready   <= 1'b0;
      case (state)
        IDLE: if (start) begin
          lo       <= '0;
          hi       <= HI_RST;
          pair_idx <= PAIR_RST;
          svm_req  <= 1'b1;
          busy     <= 1'b1;
          state    <= EVAL;
        end
        EVAL: if (svm_ready) begin
          lo <= nlo;
          hi <= nhi;
          if (nlo == nhi) begin
            winner <= nlo;
            busy   <= 1'b0;
            ready  <= 1'b1;
            state  <= DONE;
          end else begin
            pair_idx <= PAIR_W'(pair_index(int'(nlo), int'(nhi), N_CLASS));
            svm_req  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  a_no_cross: assert property (@(posedge clk) disable iff (!rst_n) (state == EVAL) |-> (lo < hi));

  svm_pair_rom #(
    .N_PAIRS   (N_PAIRS),
    .PAIR_W    (PAIR_W),
    .N_FEATURES(N_FEATURES),
    .WEIGHT_W  (WEIGHT_W),
    .BIAS_W    (BIAS_W)
  ) u_rom (
    .pair_idx(pair_idx),
    .weight  (weight),
    .bias    (bias)
  );

endmodule

// File: tb/tb_svm_dag_picker.sv
// Directed bench for svm_dag_picker: a 4-class and a 2-class instance on a shared clock/reset.
module tb_svm_dag_picker;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, svm_ready, w_class;
  logic         svm_req, busy, ready;
  logic [167:0] weight;
  logic [15:0]  bias;
  logic [2:0]   pair_idx;
  logic [1:0]   winner;

  logic         start2, svm_ready2, w_class2;
  logic         svm_req2, busy2, ready2;
  logic [167:0] weight2;
  logic [15:0]  bias2;
  logic [0:0]   pair_idx2;
  logic [0:0]   winner2;

  int vec = 0;
  int errs = 0;
  int req_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (svm_req === 1'b1) req_cnt <= req_cnt + 1;

  svm_dag_picker #(.N_CLASS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .svm_ready(svm_ready), .w_class(w_class),
    .svm_req(svm_req), .weight(weight), .bias(bias), .pair_idx(pair_idx),
    .busy(busy), .ready(ready), .winner(winner)
  );

  svm_dag_picker #(.N_CLASS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .svm_ready(svm_ready2), .w_class(w_class2),
    .svm_req(svm_req2), .weight(weight2), .bias(bias2), .pair_idx(pair_idx2),
    .busy(busy2), .ready(ready2), .winner(winner2)
  );

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; svm_ready = 0; w_class = 0;
    start2 = 0; svm_ready2 = 0; w_class2 = 0;
    repeat (3) cyc();
    vec++;
    if (busy !== 1'b0 || ready !== 1'b0 || svm_req !== 1'b0 || winner !== 2'd0 || pair_idx !== 3'd2) begin
      errs++; $display("FAIL reset4: busy=%b ready=%b req=%b win=%0d idx=%0d, want 0 0 0 0 2",
                       busy, ready, svm_req, winner, pair_idx);
    end
    vec++;
    if (busy2 !== 1'b0 || ready2 !== 1'b0 || svm_req2 !== 1'b0 || winner2 !== 1'b0 || pair_idx2 !== 1'b0) begin
      errs++; $display("FAIL reset2: busy=%b ready=%b req=%b win=%0d idx=%0d, want all 0",
                       busy2, ready2, svm_req2, winner2, pair_idx2);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_all_lo();
    int ep[3] = '{2, 1, 0};
    int base;
    base = req_cnt;
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 3; k++) begin
      vec++;
      if (svm_req !== 1'b1 || pair_idx !== 3'(ep[k])) begin
        errs++; $display("FAIL lo_pair%0d: req=%b idx=%0d, want req=1 idx=%0d", k, svm_req, pair_idx, ep[k]);
      end
      svm_ready = 1; w_class = 0; cyc(); svm_ready = 0;
    end
    vec++;
    if (ready !== 1'b1 || winner !== 2'd0 || busy !== 1'b0) begin
      errs++; $display("FAIL lo_done: ready=%b win=%0d busy=%b, want 1 0 0", ready, winner, busy);
    end
    cyc();
    vec++;
    if (ready !== 1'b0 || winner !== 2'd0) begin
      errs++; $display("FAIL lo_after: ready=%b win=%0d, want 0 0", ready, winner);
    end
    vec++;
    if (req_cnt - base !== 3) begin
      errs++; $display("FAIL lo_reqcnt: got %0d pulses, want 3", req_cnt - base);
    end
  endtask

  task automatic test_all_hi();
    int ep[3] = '{2, 4, 5};
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 3; k++) begin
      vec++;
      if (svm_req !== 1'b1 || pair_idx !== 3'(ep[k]) || busy !== 1'b1) begin
        errs++; $display("FAIL hi_pair%0d: req=%b idx=%0d busy=%b, want 1 %0d 1", k, svm_req, pair_idx, busy, ep[k]);
      end
      svm_ready = 1; w_class = 1; cyc(); svm_ready = 0;
    end
    vec++;
    if (ready !== 1'b1 || winner !== 2'd3 || busy !== 1'b0) begin
      errs++; $display("FAIL hi_done: ready=%b win=%0d busy=%b, want 1 3 0", ready, winner, busy);
    end
    cyc();
  endtask

  task automatic test_mixed_gap();
    int         ep[3]  = '{2, 4, 3};
    logic       wv[3]  = '{1'b1, 1'b0, 1'b1};
    logic [7:0] ew0[3] = '{8'hCF, 8'h19, 8'hF4};
    logic [7:0] ew20[3] = '{8'hAB, 8'hF5, 8'hD0};
    logic [15:0] eb[3] = '{16'hFE0C, 16'h05DC, 16'h01F4};
    start = 1; cyc(); start = 0;
    for (int k = 0; k < 3; k++) begin
      vec++;
      if (svm_req !== 1'b1 || pair_idx !== 3'(ep[k])) begin
        errs++; $display("FAIL mix_pair%0d: req=%b idx=%0d, want 1 %0d", k, svm_req, pair_idx, ep[k]);
      end
      vec++;
      if (weight[7:0] !== ew0[k] || weight[167:160] !== ew20[k] || bias !== eb[k]) begin
        errs++; $display("FAIL mix_rom%0d: w0=%h w20=%h b=%h, want %h %h %h",
                         k, weight[7:0], weight[167:160], bias, ew0[k], ew20[k], eb[k]);
      end
      for (int g = 0; g < 10; g++) begin
        cyc();
        vec++;
        if (svm_req !== 1'b0 || weight[7:0] !== ew0[k] || bias !== eb[k] || busy !== 1'b1) begin
          errs++; $display("FAIL mix_hold%0d_%0d: req=%b w0=%h b=%h busy=%b, want 0 %h %h 1",
                           k, g, svm_req, weight[7:0], bias, busy, ew0[k], eb[k]);
        end
      end
      svm_ready = 1; w_class = wv[k]; cyc(); svm_ready = 0;
    end
    vec++;
    if (ready !== 1'b1 || winner !== 2'd2) begin
      errs++; $display("FAIL mix_done: ready=%b win=%0d, want 1 2", ready, winner);
    end
    cyc();
  endtask

  task automatic test_ignored();
    int base;
    base = req_cnt;
    svm_ready = 1; w_class = 1; cyc(); svm_ready = 0;
    vec++;
    if (busy !== 1'b0 || svm_req !== 1'b0 || winner !== 2'd2) begin
      errs++; $display("FAIL ign_idle: busy=%b req=%b win=%0d, want 0 0 2", busy, svm_req, winner);
    end
    start = 1; svm_ready = 1; w_class = 1; cyc(); svm_ready = 0;
    vec++;
    if (svm_req !== 1'b1 || pair_idx !== 3'd2 || winner !== 2'd2) begin
      errs++; $display("FAIL ign_startwins: req=%b idx=%0d win=%0d, want 1 2 2", svm_req, pair_idx, winner);
    end
    cyc(); start = 0;
    vec++;
    if (svm_req !== 1'b0 || pair_idx !== 3'd2 || busy !== 1'b1) begin
      errs++; $display("FAIL ign_restart: req=%b idx=%0d busy=%b, want 0 2 1", svm_req, pair_idx, busy);
    end
    svm_ready = 1; w_class = 0; cyc(); svm_ready = 0;
    start = 1; cyc(); start = 0;
    vec++;
    if (svm_req !== 1'b0 || pair_idx !== 3'd1) begin
      errs++; $display("FAIL ign_restart2: req=%b idx=%0d, want 0 1", svm_req, pair_idx);
    end
    svm_ready = 1; w_class = 0; cyc();
    w_class = 1; cyc(); svm_ready = 0;
    vec++;
    if (ready !== 1'b1 || winner !== 2'd1) begin
      errs++; $display("FAIL ign_done: ready=%b win=%0d, want 1 1", ready, winner);
    end
    vec++;
    if (req_cnt - base !== 3) begin
      errs++; $display("FAIL ign_reqcnt: got %0d pulses, want 3", req_cnt - base);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    start = 1; cyc(); start = 0;
    svm_ready = 1; w_class = 1; cyc();
    w_class = 0; cyc(); svm_ready = 0;
    vec++;
    if (svm_req !== 1'b1 || pair_idx !== 3'd3) begin
      errs++; $display("FAIL rst_pre: req=%b idx=%0d, want 1 3", svm_req, pair_idx);
    end
    svm_ready = 1; w_class = 1;
    #1 rst_n = 0;
    #1;
    vec++;
    if (busy !== 1'b0 || ready !== 1'b0 || winner !== 2'd0 || svm_req !== 1'b0 || pair_idx !== 3'd2) begin
      errs++; $display("FAIL rst_async: busy=%b ready=%b win=%0d req=%b idx=%0d, want 0 0 0 0 2",
                       busy, ready, winner, svm_req, pair_idx);
    end
    cyc(); rst_n = 1; svm_ready = 0;
    cyc();
    vec++;
    if (busy !== 1'b0 || svm_req !== 1'b0) begin
      errs++; $display("FAIL rst_lost: busy=%b req=%b, want 0 0", busy, svm_req);
    end
    start = 1; cyc(); start = 0;
    vec++;
    if (svm_req !== 1'b1 || pair_idx !== 3'd2) begin
      errs++; $display("FAIL rst_restart: req=%b idx=%0d, want 1 2", svm_req, pair_idx);
    end
    svm_ready = 1; w_class = 1; repeat (3) cyc(); svm_ready = 0;
    vec++;
    if (ready !== 1'b1 || winner !== 2'd3) begin
      errs++; $display("FAIL rst_done: ready=%b win=%0d, want 1 3", ready, winner);
    end
    cyc();
  endtask

  task automatic test_two_class();
    start2 = 1; cyc(); start2 = 0;
    vec++;
    if (svm_req2 !== 1'b1 || pair_idx2 !== 1'b0 || busy2 !== 1'b1) begin
      errs++; $display("FAIL n2_req: req=%b idx=%0d busy=%b, want 1 0 1", svm_req2, pair_idx2, busy2);
    end
    vec++;
    if (weight2[7:0] !== 8'h85 || bias2 !== 16'hF63C) begin
      errs++; $display("FAIL n2_rom: w0=%h b=%h, want 85 f63c", weight2[7:0], bias2);
    end
    svm_ready2 = 1; w_class2 = 1; cyc(); svm_ready2 = 0;
    vec++;
    if (ready2 !== 1'b1 || winner2 !== 1'b1 || busy2 !== 1'b0 || svm_req2 !== 1'b0) begin
      errs++; $display("FAIL n2_done: ready=%b win=%0d busy=%b req=%b, want 1 1 0 0", ready2, winner2, busy2, svm_req2);
    end
    cyc();
    vec++;
    if (ready2 !== 1'b0 || winner2 !== 1'b1) begin
      errs++; $display("FAIL n2_hold: ready=%b win=%0d, want 0 1", ready2, winner2);
    end
  endtask

  initial begin
    test_reset();
    test_all_lo();
    test_all_hi();
    test_mixed_gap();
    test_ignored();
    test_reset_mid();
    test_two_class();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
